sha256_mem_host: RTL

//  Memory-side responder and job sequencer for the SHA-256 engine's word memory interface.

---
 rtl/sha256_mem_host.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sha256_mem_host.sv
// Word memory and job sequencer for the SHA-256 engine: loads a message from the host stream,
// runs the engine, times it, and streams the eight hash words back to the host.
//
// state   | meaning
// IDLE    | waiting for the first message word
// LOAD    | accepting the remaining message words
// START   | one-cycle engine start pulse, run counter cleared to 1
// WAIT_LO | waiting for the engine to drop done
// WAIT_HI | waiting for the engine to raise done
// DRAIN   | streaming hash words h0..h7 to the host
module sha256_mem_host #(
   parameter int DEPTH     = 64,
   parameter int MSG_WORDS = 20,
   parameter int MSG_ADDR  = 0,
   parameter int OUT_ADDR  = 32
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_last,
   output logic        busy,
   output logic        err,
   output logic [31:0] run_cycles,
   output logic        eng_start,
   input  logic        eng_done,
   output logic [15:0] eng_message_addr,
   output logic [15:0] eng_output_addr,
   input  logic        mem_we,
   input  logic [15:0] mem_addr,
   input  logic [31:0] mem_write_data,
   output logic [31:0] mem_read_data
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(MSG_WORDS + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_START, S_WAIT_LO, S_WAIT_HI, S_DRAIN
   } state_t;

   state_t        state, state_nxt;
   logic [31:0]   mem [DEPTH];
   logic [CW-1:0] word_cnt;
   logic [2:0]    hash_idx;
   logic [2:0]    rd_idx;
   logic [31:0]   run_cnt;
   logic          a_in_range, a_wr, b_wr, in_fire, last_word, out_fire;
   logic [AW-1:0] a_idx, b_widx, b_ridx;

   assign eng_message_addr = 16'(MSG_ADDR);
   assign eng_output_addr  = 16'(OUT_ADDR);
   assign in_ready  = (state == S_IDLE) || (state == S_LOAD);
   assign eng_start = (state == S_START);
   assign busy      = (state != S_IDLE);

   assign in_fire    = in_valid && in_ready;
   assign last_word  = (word_cnt == CW'(MSG_WORDS - 1));
   assign out_fire   = out_valid && out_ready;
   assign a_in_range = (mem_addr < 16'(DEPTH));
   assign a_idx      = mem_addr[AW-1:0];
   assign a_wr       = mem_we && a_in_range;
   assign b_widx     = AW'(MSG_ADDR) + AW'(word_cnt);
   // engine write has priority over a host load to the same word
   assign b_wr       = in_fire && !(a_wr && (a_idx == b_widx));
   // while a word is being presented, prefetch the next one so handshakes run back to back
   assign rd_idx     = hash_idx + {2'b00, out_valid};
   assign b_ridx     = AW'(OUT_ADDR) + AW'(rd_idx);

   always_ff @(posedge clk) begin
      if (a_wr) mem[a_idx] <= mem_write_data;
      if (b_wr) mem[b_widx] <= in_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_read_data <= '0;
         err           <= 1'b0;
      end else begin
         mem_read_data <= a_in_range ? mem[a_idx] : '0;
         if (!a_in_range) err <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         word_cnt   <= '0;
         hash_idx   <= '0;
         run_cnt    <= '0;
         run_cycles <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         out_data   <= '0;
      end else begin
         state <= state_nxt;
         if (in_fire) word_cnt <= last_word ? '0 : word_cnt + CW'(1);
         case (state)
            S_START:   run_cnt <= 32'd1;
            S_WAIT_LO: run_cnt <= (run_cnt == '1) ? run_cnt : run_cnt + 32'd1;
            S_WAIT_HI: begin
               if (eng_done) begin
                  run_cycles <= run_cnt;
                  hash_idx   <= '0;
               end else begin
                  run_cnt <= (run_cnt == '1) ? run_cnt : run_cnt + 32'd1;
               end
            end
            S_DRAIN: begin
               if (!out_valid) begin
                  out_data  <= mem[b_ridx];
                  out_valid <= 1'b1;
                  out_last  <= (hash_idx == 3'd7);
               end else if (out_ready) begin
                  if (hash_idx == 3'd7) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                  end else begin
                     hash_idx <= hash_idx + 3'd1;
                     out_data <= mem[b_ridx];
                     out_last <= (hash_idx == 3'd6);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_LOAD: if (in_fire) state_nxt = last_word ? S_START : S_LOAD;
         S_START:        state_nxt = S_WAIT_LO;
         S_WAIT_LO:      if (!eng_done) state_nxt = S_WAIT_HI;
         S_WAIT_HI:      if (eng_done) state_nxt = S_DRAIN;
         S_DRAIN:        if (out_fire && (hash_idx == 3'd7)) state_nxt = S_IDLE;
         default:        state_nxt = S_IDLE;
      endcase
   end
endmodule
